rv_writeback_lsq: RTL and testbench
===================================

RV_WRITEBACK_LSQ -- requirements
Module: rv_writeback_lsq

Interface
REQ-001 SHALL have parameter DEPTH, default 2, the maximum number of outstanding memory ops; it is a power of 2 and at least 2.
REQ-002 SHALL have parameter XLEN, default 32, the data width; only 32 is supported.
REQ-003 clk_i  in  1  clock; the block has one clock, and all state is on its rising edge.
REQ-004 rst_i  in  1  reset, synchronous and active-high.
REQ-005 w_stall_i  in  1  global stall; it blocks enqueue and register-file writes.
REQ-006 w_stall_req_o  out  1  stall request to the pipeline.
REQ-007 x_fun_i  in  3  load/store size code (LDST_B/BU/H/HU/L).
REQ-008 x_load_i, x_store_i, x_load_hazard_i  in  1 each  memory-op valid strobes and the dependent-use flag.
REQ-009 x_dm_addr_i  in  XLEN  data address; only bits [1:0] are stored.
REQ-010 x_rd_i  in  5, x_rd_value_i  in  XLEN, x_rd_write_i  in  1  non-memory writeback request.
REQ-011 dm_data_l_i  in  XLEN, dm_load_done_i  in  1, dm_store_done_i  in  1  in-order memory completions.
REQ-012 rf_rd_o  out  5, rf_rd_value_o  out  XLEN, rf_rd_write_o  out  1  register-file write port.
REQ-013 x_misaligned_o  out  1  misaligned-access pulse; present only with URV_MISALIGN_TRAP_EN.

Function
REQ-014 SHALL keep a FIFO of DEPTH entries {is_load, fun, addr[1:0], rd, hazard}, written when (x_load_i|x_store_i) && !w_stall_i && !full.
REQ-015 SHALL complete the head entry on dm_load_done_i if the head is a load, or on dm_store_done_i if the head is a store; a done pulse that mismatches the head, or arrives with the FIFO empty, is ignored.
REQ-016 SHALL accept an enqueue and a dequeue in the same cycle when full, with occupancy unchanged; pointers wrap modulo DEPTH.
REQ-017 SHALL write a completing load to the register file combinationally in the done cycle (zero latency), using the head's rd and the head's fun/addr for byte-lane extraction.
REQ-018 SHALL perform byte-lane extraction as follows: B/BU selects lane addr[1:0] with sign/zero extension; H/HU selects [15:0] or [31:16] by addr[1] with sign/zero extension; L passes the word through.
REQ-019 SHALL give a load completion priority over a same-cycle non-memory write; the non-memory instruction is held by w_stall_req_o and written the next cycle.
REQ-020 SHALL stall a non-memory write (x_rd_write_i, no memory op) while any load is outstanding and not completing, so that writeback stays in program order.
REQ-021 SHALL assert w_stall_req_o when: a memory op arrives and the FIFO is full without a same-cycle dequeue; or REQ-019/REQ-020 applies; or the hold register is busy; or the interlock cycle is active.
REQ-022 SHALL, when a load with hazard=1 completes, insert exactly one interlock cycle: w_stall_req_o=1 and rf_rd_write_o=0 on the following cycle.
REQ-023 SHALL, when a load completes while w_stall_i=1, capture rd and the extracted value in a one-entry hold register and write it on the first cycle with w_stall_i=0.
REQ-024 SHALL force rf_rd_write_o=0 whenever rd==0 or w_stall_i=1.
REQ-025 SHALL drive rf_rd_value_o=x_rd_value_i and rf_rd_o=x_rd_i when no load result is being written.

Reset
REQ-026 SHALL, on rst_i, empty the FIFO, clear the hold register and interlock, and drive w_stall_req_o=0, rf_rd_write_o=0 and x_misaligned_o=0 in the next cycle.
REQ-027 SHALL, on reset during outstanding ops, discard all entries; later stray done pulses are ignored (REQ-015).

Configuration
REQ-028 SHALL, with URV_MISALIGN_TRAP_EN defined, flag H/HU with addr[0]=1 and L with addr[1:0]!=0: the op is not enqueued, x_misaligned_o pulses for 1 cycle, and no register write occurs.
REQ-029 SHALL, without URV_MISALIGN_TRAP_EN, omit x_misaligned_o, use addr[1] for halfword lane selection, and ignore address bits for L.

Structure
REQ-030 SHALL take the LDST_* codes from the shared definitions package, and SHALL place the FIFO entry typedef and the DEPTH-derived pointer width there.
REQ-031 SHALL contain one combinational sub-module, rv_load_align (fun, addr[1:0], data -> value), reused by the FIFO path and the hold path.

Verification
REQ-032 LB at addr 0x...3 with dm_data_l_i=0x80xxxxxx, done in the same cycle -> rf_rd_value_o=0xFFFFFF80, rf_rd_write_o=1 in that cycle.
REQ-033 Two LWs to rd 5 and rd 6 with DEPTH=2, a third memory op in the next cycle -> w_stall_req_o=1 until the first done; writes go to 5 then 6.
REQ-034 LHU with hazard=1, done -> rf write in cycle N; cycle N+1 shows w_stall_req_o=1 and rf_rd_write_o=0.
REQ-035 Load done while w_stall_i=1 for 3 cycles -> no write during the stall; the value is written in the first cycle after w_stall_i falls.
REQ-036 With URV_MISALIGN_TRAP_EN, LW at addr 0x2 -> x_misaligned_o=1 for 1 cycle and the FIFO stays empty; without the macro, the same LW enqueues and returns the full word.
REQ-037 rst_i asserted with 2 loads outstanding, then dm_load_done_i pulses -> rf_rd_write_o stays 0.

Source files
------------

// File: rtl/rv_writeback_lsq_pkg.sv
// Shared definitions for the writeback / load-store queue block:
// load/store size codes, the queue entry layout and the pointer-width helper.
package rv_writeback_lsq_pkg;

    // Load/store size codes (RISC-V funct3 encoding).
    localparam logic [2:0] LDST_B  = 3'b000;
    localparam logic [2:0] LDST_H  = 3'b001;
    localparam logic [2:0] LDST_L  = 3'b010;
    localparam logic [2:0] LDST_BU = 3'b100;
    localparam logic [2:0] LDST_HU = 3'b101;

    // One outstanding memory operation.
    typedef struct packed {
        logic       is_load;
        logic [2:0] fun;
        logic [1:0] addr;
        logic [4:0] rd;
        logic       hazard;
    } lsq_entry_t;

    // Pointer width for a queue of the given (power-of-2) depth.
    function automatic int lsq_ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/rv_writeback_lsq_align.sv
// rv_load_align: extracts and extends the addressed byte/halfword of a
// loaded word according to the load size code. Purely combinational.
module rv_load_align
    import rv_writeback_lsq_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      fun,
    input  logic [1:0]      addr,
    input  logic [XLEN-1:0] data,
    output logic [XLEN-1:0] value
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    assign lane_b = data[{addr, 3'b000} +: 8];
    assign lane_h = addr[1] ? data[31:16] : data[15:0];

    // Select the lane and apply sign or zero extension.
    always_comb begin
        // NOTE: default assignment first so every path drives value; no latch.
        value = data;
        case (fun)
            LDST_B:  value = {{(XLEN-8){lane_b[7]}}, lane_b};
            LDST_BU: value = {{(XLEN-8){1'b0}}, lane_b};
            LDST_H:  value = {{(XLEN-16){lane_h[15]}}, lane_h};
            LDST_HU: value = {{(XLEN-16){1'b0}}, lane_h};
            default: value = data;
        endcase
    end

endmodule

// File: rtl/rv_writeback_lsq.sv
// rv_writeback_lsq: in-order queue of outstanding loads/stores plus the
// register-file writeback mux. Load results are written in their done cycle,
// parked in a one-entry hold register while the pipeline is stalled, and a
// hazard-flagged load adds one interlock cycle.
// Optional feature: define URV_MISALIGN_TRAP_EN to reject misaligned H/HU/L
// accesses and pulse x_misaligned_o.
module rv_writeback_lsq
    import rv_writeback_lsq_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int XLEN  = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            w_stall_i,
    output logic            w_stall_req_o,
    input  logic [2:0]      x_fun_i,
    input  logic            x_load_i,
    input  logic            x_store_i,
    input  logic            x_load_hazard_i,
    input  logic [XLEN-1:0] x_dm_addr_i,
    input  logic [4:0]      x_rd_i,
    input  logic [XLEN-1:0] x_rd_value_i,
    input  logic            x_rd_write_i,
    input  logic [XLEN-1:0] dm_data_l_i,
    input  logic            dm_load_done_i,
    input  logic            dm_store_done_i,
    output logic [4:0]      rf_rd_o,
    output logic [XLEN-1:0] rf_rd_value_o,
    output logic            rf_rd_write_o
`ifdef URV_MISALIGN_TRAP_EN
    ,
    output logic            x_misaligned_o
`endif
);

    localparam int              PTR_W    = lsq_ptr_width(DEPTH);
    localparam logic [PTR_W:0]  FULL_CNT = (PTR_W+1)'(DEPTH);

    lsq_entry_t             mem [DEPTH];
    lsq_entry_t             head;
    lsq_entry_t             new_entry;
    logic [PTR_W-1:0]       wr_ptr, rd_ptr;
    logic [PTR_W:0]         count, load_cnt;
    logic                   hold_valid;
    logic [4:0]             hold_rd;
    logic [XLEN-1:0]        hold_value;
    logic                   interlock;
    logic [XLEN-1:0]        load_value;
    logic                   mem_op, misalign, full, empty, deq, load_done, enq;
    logic                   stall_other, full_stall, nonmem_wr, nonmem_block;
    logic                   hold_write, fifo_write, capture;
    logic [XLEN-3:0]        addr_unused;

    // Only the byte offset of the data address is kept.
    assign addr_unused = x_dm_addr_i[XLEN-1:2];

    assign new_entry = '{is_load: x_load_i, fun: x_fun_i, addr: x_dm_addr_i[1:0],
                         rd: x_rd_i, hazard: x_load_hazard_i};
    assign head      = mem[rd_ptr];
    assign mem_op    = x_load_i | x_store_i;
    assign empty     = (count == '0);
    assign full      = (count == FULL_CNT);

    // A done pulse only counts if it matches the kind of op at the head.
    assign deq       = !empty && (head.is_load ? dm_load_done_i : dm_store_done_i);
    assign load_done = deq && head.is_load;

    assign stall_other  = hold_valid | interlock;
    assign full_stall   = mem_op && !misalign && full && !deq;
    // A memory op is taken exactly when it is not being stalled back.
    assign enq          = mem_op && !misalign && !w_stall_i && !stall_other && (!full || deq);
    assign nonmem_wr    = x_rd_write_i && !mem_op;
    // Any outstanding load (completing or not) keeps a plain write behind it.
    assign nonmem_block = nonmem_wr && ((load_cnt != '0) || stall_other);
    assign w_stall_req_o = full_stall | nonmem_block | stall_other;

    // The hold register drains first; a load that cannot write now is parked.
    assign hold_write = hold_valid && !w_stall_i && !interlock;
    assign fifo_write = load_done && !w_stall_i && !hold_valid && !interlock;
    assign capture    = load_done && !fifo_write;

`ifdef URV_MISALIGN_TRAP_EN
    // Detect halfword/word accesses that are not naturally aligned.
    always_comb begin
        misalign = 1'b0;
        if (mem_op) begin
            case (x_fun_i)
                LDST_H, LDST_HU: misalign = x_dm_addr_i[0];
                LDST_L:          misalign = |x_dm_addr_i[1:0];
                default:         misalign = 1'b0;
            endcase
        end
    end

    // One-cycle misalignment pulse for an op the pipeline is handing over.
    always_ff @(posedge clk_i) begin
        if (rst_i) x_misaligned_o <= 1'b0;
        else       x_misaligned_o <= misalign && !w_stall_i && !stall_other;
    end
`else
    assign misalign = 1'b0;
`endif

    // Queue storage; validity is tracked by count, not by the contents.
    always_ff @(posedge clk_i) begin
        // NOTE: entry storage is deliberately not reset; stale entries are never read as valid.
        if (enq) mem[wr_ptr] <= new_entry;
    end

    // Queue pointers, occupancy and outstanding-load count.
    always_ff @(posedge clk_i) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst_i) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            load_cnt <= '0;
        end else begin
            if (enq) wr_ptr <= wr_ptr + PTR_W'(1);
            if (deq) rd_ptr <= rd_ptr + PTR_W'(1);
            count    <= count + (PTR_W+1)'(enq) - (PTR_W+1)'(deq);
            load_cnt <= load_cnt + (PTR_W+1)'(enq && x_load_i) - (PTR_W+1)'(load_done);
        end
    end

    // Hold register for stalled load results, and the hazard interlock flag.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hold_valid <= 1'b0;
            hold_rd    <= '0;
            hold_value <= '0;
            interlock  <= 1'b0;
        end else begin
            interlock <= load_done && head.hazard;
            if (capture) begin
                hold_valid <= 1'b1;
                hold_rd    <= head.rd;
                hold_value <= load_value;
            end else if (hold_write) begin
                hold_valid <= 1'b0;
            end
        end
    end

    rv_load_align #(.XLEN(XLEN)) u_align (
        .fun   (head.fun),
        .addr  (head.addr),
        .data  (dm_data_l_i),
        .value (load_value)
    );

    // Register-file write port: hold result, then queue result, then plain write.
    always_comb begin
        rf_rd_o       = x_rd_i;
        rf_rd_value_o = x_rd_value_i;
        rf_rd_write_o = 1'b0;
        if (hold_write) begin
            rf_rd_o       = hold_rd;
            rf_rd_value_o = hold_value;
            rf_rd_write_o = 1'b1;
        end else if (fifo_write) begin
            rf_rd_o       = head.rd;
            rf_rd_value_o = load_value;
            rf_rd_write_o = 1'b1;
        end else begin
            rf_rd_write_o = nonmem_wr && !nonmem_block;
        end
        if (rf_rd_o == 5'd0 || w_stall_i) rf_rd_write_o = 1'b0;
    end

endmodule

// File: tb/tb_rv_writeback_lsq.sv
// Self-checking bench for rv_writeback_lsq: a table of single-load alignment
// vectors, hand-written multi-cycle sequences, and a randomized run checked
// against a queue-based reference model.
module tb_rv_writeback_lsq;
    import rv_writeback_lsq_pkg::*;

    localparam int DEPTH = 2;

    logic        clk_i = 1'b0;
    logic        rst_i, w_stall_i, w_stall_req_o;
    logic [2:0]  x_fun_i;
    logic        x_load_i, x_store_i, x_load_hazard_i;
    logic [31:0] x_dm_addr_i, x_rd_value_i, dm_data_l_i, rf_rd_value_o;
    logic [4:0]  x_rd_i, rf_rd_o;
    logic        x_rd_write_i, dm_load_done_i, dm_store_done_i, rf_rd_write_o;
`ifdef URV_MISALIGN_TRAP_EN
    logic        x_misaligned_o;
`endif

    rv_writeback_lsq #(.DEPTH(DEPTH), .XLEN(32)) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .w_stall_i       (w_stall_i),
        .w_stall_req_o   (w_stall_req_o),
        .x_fun_i         (x_fun_i),
        .x_load_i        (x_load_i),
        .x_store_i       (x_store_i),
        .x_load_hazard_i (x_load_hazard_i),
        .x_dm_addr_i     (x_dm_addr_i),
        .x_rd_i          (x_rd_i),
        .x_rd_value_i    (x_rd_value_i),
        .x_rd_write_i    (x_rd_write_i),
        .dm_data_l_i     (dm_data_l_i),
        .dm_load_done_i  (dm_load_done_i),
        .dm_store_done_i (dm_store_done_i),
        .rf_rd_o         (rf_rd_o),
        .rf_rd_value_o   (rf_rd_value_o),
        .rf_rd_write_o   (rf_rd_write_o)
`ifdef URV_MISALIGN_TRAP_EN
        ,
        .x_misaligned_o  (x_misaligned_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are read 3 later.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        w_stall_i = 0; x_fun_i = '0; x_load_i = 0; x_store_i = 0; x_load_hazard_i = 0;
        x_dm_addr_i = '0; x_rd_i = '0; x_rd_value_i = '0; x_rd_write_i = 0;
        dm_data_l_i = '0; dm_load_done_i = 0; dm_store_done_i = 0;
    endtask

    task automatic issue(input bit is_load, input logic [2:0] fun, input logic [1:0] addr,
                         input logic [4:0] rd, input bit hazard);
        x_load_i = is_load; x_store_i = !is_load; x_fun_i = fun;
        x_dm_addr_i = {30'h0, addr}; x_rd_i = rd; x_load_hazard_i = hazard;
        tick();
        x_load_i = 0; x_store_i = 0; x_load_hazard_i = 0; x_rd_i = '0;
    endtask

    // Reference lane extraction, written with shifts and masks.
    function automatic logic [31:0] extract(input logic [2:0] fun, input logic [1:0] addr,
                                            input logic [31:0] w);
        logic [31:0] b, h;
        b = (w >> (8 * addr)) & 32'hFF;
        h = (w >> (16 * addr[1])) & 32'hFFFF;
        case (fun)
            LDST_B:  return b[7]  ? (b | 32'hFFFF_FF00) : b;
            LDST_BU: return b;
            LDST_H:  return h[15] ? (h | 32'hFFFF_0000) : h;
            LDST_HU: return h;
            default: return w;
        endcase
    endfunction

    typedef struct {
        logic [2:0]  fun;
        logic [1:0]  addr;
        logic [31:0] data;
        logic [4:0]  rd;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        bit         is_load;
        logic [2:0] fun;
        logic [1:0] addr;
        logic [4:0] rd;
        bit         hazard;
    } op_t;

    vec_t        vecs[10];
    op_t         q[$];
    op_t         h0;
    logic [2:0]  funs[5];
    bit          ilk, mem, ld, nm, ldd, std, hit, lhit, accept, exp_wr, exp_stall;
    int          nloads;
    logic [2:0]  r_fun;
    logic [1:0]  r_addr;
    logic [4:0]  exp_rd;
    logic [31:0] exp_val;

    initial begin
        vecs[0] = '{LDST_B,  2'd3, 32'h8012_3456, 5'd1,  32'hFFFF_FF80};
        vecs[1] = '{LDST_BU, 2'd3, 32'h8012_3456, 5'd2,  32'h0000_0080};
        vecs[2] = '{LDST_B,  2'd0, 32'h1234_56F0, 5'd3,  32'hFFFF_FFF0};
        vecs[3] = '{LDST_BU, 2'd1, 32'h1234_A5F0, 5'd4,  32'h0000_00A5};
        vecs[4] = '{LDST_B,  2'd2, 32'h127F_0000, 5'd5,  32'h0000_007F};
        vecs[5] = '{LDST_H,  2'd0, 32'h1234_8001, 5'd6,  32'hFFFF_8001};
        vecs[6] = '{LDST_H,  2'd2, 32'h8001_1234, 5'd7,  32'hFFFF_8001};
        vecs[7] = '{LDST_HU, 2'd2, 32'h8001_1234, 5'd8,  32'h0000_8001};
        vecs[8] = '{LDST_HU, 2'd0, 32'hFFFF_7FFF, 5'd9,  32'h0000_7FFF};
        vecs[9] = '{LDST_L,  2'd0, 32'hDEAD_BEEF, 5'd31, 32'hDEAD_BEEF};
        funs = '{LDST_B, LDST_BU, LDST_H, LDST_HU, LDST_L};

        idle();
        rst_i = 1;
        tick(); tick();
        rst_i = 0;
        #3;
        check("reset_stall_req", w_stall_req_o, 0);
        check("reset_rf_write", rf_rd_write_o, 0);

        // Plain writes: pass-through, rd 0 suppressed, global stall suppresses.
        x_rd_write_i = 1; x_rd_i = 5'd7; x_rd_value_i = 32'h0000_1111; #3;
        check("nm_write", rf_rd_write_o, 1);
        check("nm_rd", rf_rd_o, 7);
        check("nm_value", rf_rd_value_o, 32'h0000_1111);
        x_rd_i = 5'd0; #1;
        check("nm_rd0", rf_rd_write_o, 0);
        x_rd_i = 5'd7; w_stall_i = 1; #1;
        check("nm_wstall", rf_rd_write_o, 0);
        tick(); idle();

        // Alignment table: one load, completed the following cycle.
        for (int i = 0; i < 10; i++) begin
            issue(1, vecs[i].fun, vecs[i].addr, vecs[i].rd, 0);
            dm_load_done_i = 1; dm_data_l_i = vecs[i].data; #3;
            check($sformatf("vec%0d_write", i), rf_rd_write_o, 1);
            check($sformatf("vec%0d_rd", i), rf_rd_o, vecs[i].rd);
            check($sformatf("vec%0d_value", i), rf_rd_value_o, vecs[i].exp);
            tick(); idle();
        end

        // Two LWs fill the queue; a store behind them is held until the first done.
        x_load_i = 1; x_fun_i = LDST_L; x_rd_i = 5'd5; #3;
        check("full_lw5_nostall", w_stall_req_o, 0);
        tick(); x_rd_i = 5'd6; #3;
        check("full_lw6_nostall", w_stall_req_o, 0);
        tick(); x_load_i = 0; x_store_i = 1; x_rd_i = 5'd0; #3;
        check("full_stall_a", w_stall_req_o, 1);
        tick(); #3;
        check("full_stall_b", w_stall_req_o, 1);
        dm_load_done_i = 1; dm_data_l_i = 32'h0000_0055; #1;
        check("full_deq_stall", w_stall_req_o, 0);
        check("full_deq_write", rf_rd_write_o, 1);
        check("full_deq_rd5", rf_rd_o, 5);
        check("full_deq_val", rf_rd_value_o, 32'h0000_0055);
        tick(); x_store_i = 0; dm_data_l_i = 32'h0000_0066; #3;
        check("full_rd6_write", rf_rd_write_o, 1);
        check("full_rd6_rd", rf_rd_o, 6);
        check("full_rd6_val", rf_rd_value_o, 32'h0000_0066);
        tick(); #3;
        check("mismatch_done_ignored", rf_rd_write_o, 0);
        tick(); dm_load_done_i = 0; dm_store_done_i = 1; #3;
        check("store_done_nowrite", rf_rd_write_o, 0);
        tick(); dm_store_done_i = 0; dm_load_done_i = 1; #3;
        check("stray_done_empty", rf_rd_write_o, 0);
        tick(); idle();

        // Plain write behind an outstanding load; the load wins the done cycle.
        issue(1, LDST_L, 2'd0, 5'd10, 0);
        x_rd_write_i = 1; x_rd_i = 5'd3; x_rd_value_i = 32'h0000_0333; #3;
        check("order_blocked_stall", w_stall_req_o, 1);
        check("order_blocked_write", rf_rd_write_o, 0);
        tick(); dm_load_done_i = 1; dm_data_l_i = 32'h0000_AAAA; #3;
        check("prio_load_rd", rf_rd_o, 10);
        check("prio_load_val", rf_rd_value_o, 32'h0000_AAAA);
        check("prio_load_stall", w_stall_req_o, 1);
        tick(); dm_load_done_i = 0; #3;
        check("prio_nm_write", rf_rd_write_o, 1);
        check("prio_nm_rd", rf_rd_o, 3);
        check("prio_nm_stall", w_stall_req_o, 0);
        tick(); idle();

        // Hazard load: one interlock cycle after the write.
        issue(1, LDST_HU, 2'd2, 5'd9, 1);
        dm_load_done_i = 1; dm_data_l_i = 32'hBEEF_1234; #3;
        check("hz_write", rf_rd_write_o, 1);
        check("hz_val", rf_rd_value_o, 32'h0000_BEEF);
        tick(); dm_load_done_i = 0; x_rd_write_i = 1; x_rd_i = 5'd4; x_rd_value_i = 32'h44; #3;
        check("hz_ilk_stall", w_stall_req_o, 1);
        check("hz_ilk_nowrite", rf_rd_write_o, 0);
        tick(); #3;
        check("hz_after_stall", w_stall_req_o, 0);
        check("hz_after_write", rf_rd_write_o, 1);
        tick(); idle();

        // Load completing under a 3-cycle global stall goes through the hold register.
        issue(1, LDST_B, 2'd1, 5'd12, 0);
        w_stall_i = 1; dm_load_done_i = 1; dm_data_l_i = 32'h0000_8100; #3;
        check("hold_c0_nowrite", rf_rd_write_o, 0);
        tick(); dm_load_done_i = 0; #3;
        check("hold_c1_nowrite", rf_rd_write_o, 0);
        check("hold_c1_stallreq", w_stall_req_o, 1);
        tick(); #3;
        check("hold_c2_nowrite", rf_rd_write_o, 0);
        tick(); w_stall_i = 0; #3;
        check("hold_write", rf_rd_write_o, 1);
        check("hold_rd", rf_rd_o, 12);
        check("hold_val", rf_rd_value_o, 32'hFFFF_FF81);
        tick(); #3;
        check("hold_done_stall", w_stall_req_o, 0);
        check("hold_done_write", rf_rd_write_o, 0);
        idle();

        // Misaligned word access.
`ifdef URV_MISALIGN_TRAP_EN
        issue(1, LDST_L, 2'd2, 5'd11, 0);
        #3;
        check("mis_pulse", x_misaligned_o, 1);
        tick(); #3;
        check("mis_pulse_end", x_misaligned_o, 0);
        dm_load_done_i = 1; dm_data_l_i = 32'hCAFE_F00D; #1;
        check("mis_not_queued", rf_rd_write_o, 0);
        tick(); idle();
`else
        issue(1, LDST_L, 2'd2, 5'd11, 0);
        dm_load_done_i = 1; dm_data_l_i = 32'hCAFE_F00D; #3;
        check("lw_addr2_write", rf_rd_write_o, 1);
        check("lw_addr2_val", rf_rd_value_o, 32'hCAFE_F00D);
        tick(); idle();
`endif

        // Reset with two loads outstanding; later done pulses must be ignored.
        issue(1, LDST_L, 2'd0, 5'd7, 0);
        issue(1, LDST_L, 2'd0, 5'd8, 0);
        rst_i = 1; tick(); rst_i = 0; #3;
        check("rst_out_stall", w_stall_req_o, 0);
        check("rst_out_write", rf_rd_write_o, 0);
        dm_load_done_i = 1; dm_data_l_i = 32'h1234_5678; #1;
        check("rst_stray_a", rf_rd_write_o, 0);
        tick(); #3;
        check("rst_stray_b", rf_rd_write_o, 0);
        tick(); idle();

        // Randomized traffic against a queue model (no global stall).
        rst_i = 1; tick(); rst_i = 0;
        q.delete();
        ilk = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            idle();
            mem = ($urandom_range(0, 2) == 0);
            ld  = mem && ($urandom_range(0, 1) == 1);
            r_fun = funs[$urandom_range(0, 4)];
            case (r_fun)
                LDST_B, LDST_BU: r_addr = 2'($urandom_range(0, 3));
                LDST_H, LDST_HU: r_addr = {1'($urandom_range(0, 1)), 1'b0};
                default:         r_addr = 2'd0;
            endcase
            x_load_i = ld; x_store_i = mem && !ld; x_fun_i = r_fun;
            x_dm_addr_i = {$urandom_range(0, 255), r_addr}[31:0];
            x_rd_i = 5'($urandom_range(0, 31));
            x_load_hazard_i = ($urandom_range(0, 3) == 0);
            nm = !mem && ($urandom_range(0, 1) == 1);
            x_rd_write_i = nm; x_rd_value_i = $urandom;
            ldd = !ilk && ($urandom_range(0, 2) == 0);
            std = !ilk && ($urandom_range(0, 2) == 0);
            dm_load_done_i = ldd; dm_store_done_i = std; dm_data_l_i = $urandom;
            #3;

            nloads = 0;
            foreach (q[k]) if (q[k].is_load) nloads++;
            hit  = (q.size() > 0) && ((q[0].is_load && ldd) || (!q[0].is_load && std));
            lhit = hit && q[0].is_load;
            exp_stall = (mem && q.size() == DEPTH && !hit) || (nm && nloads > 0) || ilk;
            if (lhit) begin
                exp_wr  = (q[0].rd != 0);
                exp_rd  = q[0].rd;
                exp_val = extract(q[0].fun, q[0].addr, dm_data_l_i);
            end else begin
                exp_wr  = nm && nloads == 0 && !ilk && x_rd_i != 0;
                exp_rd  = x_rd_i;
                exp_val = x_rd_value_i;
            end
            check($sformatf("rnd%0d_write", cyc), rf_rd_write_o, exp_wr);
            check($sformatf("rnd%0d_stall", cyc), w_stall_req_o, exp_stall);
            if (exp_wr) begin
                check($sformatf("rnd%0d_rd", cyc), rf_rd_o, exp_rd);
                check($sformatf("rnd%0d_value", cyc), rf_rd_value_o, exp_val);
            end

            accept = mem && !ilk && (q.size() < DEPTH || hit);
            ilk = 0;
            if (hit) begin
                h0 = q.pop_front();
                ilk = h0.is_load && h0.hazard;
            end
            if (accept) q.push_back('{ld, r_fun, r_addr, x_rd_i, x_load_hazard_i});
            tick();
        end
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
